// File: rtl/w_74hc190_counter.sv
// Presettable up/down modulo-N counter (74HC190/191 style) with terminal count,
// one-cycle wrap pulse and a divide-by-2N square-wave output.
module w_74hc190_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UD,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             DIV
);

    generate
        if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
            $error("w_74hc190_counter: WIDTH must be in 2..8");
        end
        if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
            $error("w_74hc190_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } wrap_state_t;

    wrap_state_t      state;
    logic             count_en;
    logic             at_max;
    logic             at_zero;
    logic             wrap_take;
    logic [WIDTH-1:0] d_sat;

    assign at_max   = (Q == Q_MAX);
    assign at_zero  = (Q == '0);
    assign count_en = ENP & ENT;
    // Load has priority, so a load edge never counts as a wrap
    assign wrap_take = ~LD & count_en & (UD ? at_max : at_zero);
    // Out-of-range load values saturate so Q never reaches an illegal state
    assign d_sat = (32'(D) >= MODULUS) ? Q_MAX : D;

    // TC is gated by ENT only, which keeps it valid for cascading
    assign TC   = ENT & (UD ? at_max : at_zero);
    assign WRAP = (state == S_PULSE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q     <= '0;
            DIV   <= 1'b0;
            state <= S_IDLE;
        end else begin
            if (LD) begin
                Q <= d_sat;
            end else if (count_en) begin
                if (UD) begin
                    Q <= at_max ? '0 : Q + WIDTH'(1);
                end else begin
                    Q <= at_zero ? Q_MAX : Q - WIDTH'(1);
                end
            end

            if (wrap_take) begin
                DIV <= ~DIV;
            end

            case (state)
                S_IDLE:  if (wrap_take)  state <= S_PULSE;
                S_PULSE: if (!wrap_take) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
